pipe_skid_reg: RTL and testbench
================================

Name: pipe_skid_reg

Overview:
Parametrised pipeline-stage register with a valid/ready handshake on both sides, a 2-entry skid buffer, and synchronous flush.
Replaces plain load-enabled registers between CPU pipeline stages (IF/ID, ID/EX, ...) wherever backpressure or hazard-driven squash is needed.
Sustains full throughput (one transfer per cycle) with no combinational path from out_ready to in_ready.

Parameters:
SIZE, 64, payload width in bits (>=1)
RESET_VAL, 0, value of both data registers after reset (SIZE bits)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous squash of all held entries
in_valid  input  1  upstream presents in_data
in_ready  output  1  stage can accept in_data this cycle
in_data  input  SIZE  upstream payload
out_valid  output  1  out_data holds a valid entry
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  SIZE  head entry (main register)
occupancy  output  2  number of held entries, 0..2

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk.
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives out_data) and skid register.
- FSM states: EMPTY (0 entries), BUSY (main valid), FULL (main and skid valid).
- All outputs are decoded from registered state only:
  - in_ready = (state != FULL)
  - out_valid = (state != EMPTY)
  - occupancy = 0/1/2 for EMPTY/BUSY/FULL
- Reset, asynchronous:
  - state = EMPTY; main = skid = RESET_VAL.
  - Outputs: in_ready=1, out_valid=0, out_data=RESET_VAL, occupancy=0.
- Transitions (flush has top priority; otherwise):
  - EMPTY, in_fire: main<=in_data -> BUSY.
  - EMPTY, no in_fire: stay EMPTY.
  - BUSY, in_fire & out_fire: main<=in_data, stay BUSY.
  - BUSY, in_fire & !out_fire: skid<=in_data -> FULL.
  - BUSY, !in_fire & out_fire: -> EMPTY.
  - BUSY, neither: hold.
  - FULL, out_fire: main<=skid -> BUSY. in_fire is impossible in FULL (in_ready=0).
  - FULL, !out_fire: hold.
- Latency: an accepted word appears on out_data the next cycle when the stage was EMPTY or drained that cycle. FIFO order is always preserved.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid must not change (flush excepted).
- flush=1 at a clock edge:
  - state -> EMPTY regardless of in_valid/out_ready.
  - Any in_fire in that cycle is discarded; any out_fire in that cycle still counts as consumed downstream.
  - Data registers are not required to change.
- Reset asserted mid-transfer: everything is discarded immediately. The first post-reset edge behaves as EMPTY.
- X-safety: data registers load only on the enables above. in_data is ignored when in_valid=0.

Decomposition:
- Package pipe_pkg holds typedef enum logic [1:0] skid_state_t {EMPTY, BUSY, FULL} and the occupancy width constant OCC_W=2.
- Natural sub-module: skid_ctrl, the FSM only. It takes in_valid, out_ready and flush. It produces state, in_ready, out_valid, load_main, load_skid and main_from_skid.
- The datapath (two SIZE-bit registers plus the main-input mux) stays in pipe_skid_reg.

Test Plan:
- Reset mid-operation: hold FULL, assert reset asynchronously -> out_valid=0, in_ready=1 and out_data=RESET_VAL immediately, before the next edge.
- Streaming: in_valid=1 with values 0x1,0x2,0x3, out_ready=1 throughout -> out_data 0x1,0x2,0x3 on consecutive cycles, one cycle after each accept; occupancy stays 1.
- Backpressure fill: out_ready=0, push 0xA then 0xB:
  - Cycle after 0xB: in_ready=0, occupancy=2, out_data=0xA.
  - Raise out_ready: outputs 0xA then 0xB; in_ready returns to 1 after the first drain.
- Simultaneous in/out in BUSY: main=0x5, push 0x6 with out_ready=1 -> next cycle out_data=0x6, occupancy=1, no skid use.
- Flush in FULL with in_valid=1 (0xC) -> next cycle out_valid=0, occupancy=0, in_ready=1; 0xC never appears at the output.
- Random valid/ready with a scoreboard over 10k cycles, SIZE=8 and SIZE=64 -> no loss, no duplication, order preserved; out_data stable whenever stalled.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the skid-buffered pipeline register.
package pipe_pkg;

  localparam int OCC_W = 2;

  // Number of held entries equals the encoded state value.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  // Map a controller state to the count of held entries.
  function automatic logic [OCC_W-1:0] occ_of(input skid_state_t s);
    logic [OCC_W-1:0] occ;
    case (s)
      EMPTY:   occ = 2'd0;
      BUSY:    occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/skid_ctrl.sv
// Handshake controller for a 2-entry skid register: tracks how many entries
// are held and tells the datapath which register to load. All handshake
// outputs decode from the state register only, so out_ready never reaches
// in_ready combinationally.
module skid_ctrl
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  input  logic        out_ready,
  output skid_state_t state,
  output logic        in_ready,
  output logic        out_valid,
  output logic        load_main,
  output logic        load_skid,
  output logic        main_from_skid
);

  skid_state_t state_nxt;
  logic        in_fire;
  logic        out_fire;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // State register; reset discards everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  // Next state and load enables; flush wins and suppresses every load.
  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = (state == FULL);
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            load_main = 1'b1;
            state_nxt = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire) begin
            load_skid = 1'b1;
            state_nxt = FULL;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain path exists.
          if (out_fire) begin
            load_main = 1'b1;
            state_nxt = BUSY;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready on both sides and a skid entry,
// giving full throughput with registered in_ready. The main register always
// holds the head entry and drives out_data directly.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int              SIZE      = 64,
  parameter logic [SIZE-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIZE-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  out_data,
  output logic [OCC_W-1:0] occupancy
);

  skid_state_t     state;
  logic            load_main;
  logic            load_skid;
  logic            main_from_skid;
  logic [SIZE-1:0] main_p1;
  logic [SIZE-1:0] skid_p1;
  logic [SIZE-1:0] main_in;

  skid_ctrl u_ctrl (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .out_ready      (out_ready),
    .state          (state),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .load_main      (load_main),
    .load_skid      (load_skid),
    .main_from_skid (main_from_skid)
  );

  // When draining from FULL the skid entry moves forward; otherwise new data enters.
  assign main_in = main_from_skid ? skid_p1 : in_data;

  // ---- stage boundary: input -> held entries ----

  // Head register; loads only on an accepted word or a skid promotion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          main_p1 <= RESET_VAL;
    else if (load_main) main_p1 <= main_in;
  end

  // Skid register; captures the word accepted while the head is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          skid_p1 <= RESET_VAL;
    else if (load_skid) skid_p1 <= in_data;
  end

  assign out_data  = main_p1;
  assign occupancy = occ_of(state);

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table, reset/flush sequences and
// a random valid/ready run, with a queue model of the held entries shared by
// a 64-bit and an 8-bit instance driven with identical handshakes.
module tb_pipe_skid_reg;

  localparam logic [63:0] RV64 = 64'hDEAD_BEEF_0123_4567;
  localparam logic [7:0]  RV8  = 8'h5A;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_data64 = '0;
  logic [7:0]  in_data8;

  logic        ir64, ov64, ir8, ov8;
  logic [63:0] od64;
  logic [7:0]  od8;
  logic [1:0]  occ64, occ8;

  int errors = 0;
  int checks = 0;

  logic [63:0] q[$];
  logic        stall = 1'b0;
  logic [63:0] stall_data = '0;

  assign in_data8 = in_data64[7:0];

  always #5 clk = ~clk;

  pipe_skid_reg #(.SIZE(64), .RESET_VAL(RV64)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ir64), .in_data(in_data64),
    .out_valid(ov64), .out_ready(out_ready), .out_data(od64),
    .occupancy(occ64)
  );

  pipe_skid_reg #(.SIZE(8), .RESET_VAL(RV8)) dut8 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ir8), .in_data(in_data8),
    .out_valid(ov8), .out_ready(out_ready), .out_data(od8),
    .occupancy(occ8)
  );

  typedef struct {
    logic        iv;
    logic [63:0] d;
    logic        ordy;
    logic        fl;
    logic        eov;
    logic        eir;
    logic [1:0]  eocc;
    logic        cd;
    logic [63:0] eod;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare both instances against the queue model of held entries.
  task automatic check_outputs();
    int n;
    n = q.size();
    if (stall) begin
      chk("stable_od64", od64, stall_data);
      chk("stable_ov64", {63'd0, ov64}, 64'd1);
    end
    chk("ov64", {63'd0, ov64}, {63'd0, n > 0});
    chk("ir64", {63'd0, ir64}, {63'd0, n < 2});
    chk("occ64", {62'd0, occ64}, 64'(n));
    chk("ov8", {63'd0, ov8}, {63'd0, n > 0});
    chk("ir8", {63'd0, ir8}, {63'd0, n < 2});
    chk("occ8", {62'd0, occ8}, 64'(n));
    if (n > 0) begin
      chk("od64", od64, q[0]);
      chk("od8", {56'd0, od8}, {56'd0, q[0][7:0]});
    end
  endtask

  // One clock: drive at negedge, check and update the model, end just after posedge.
  task automatic cycle(input logic iv, input logic [63:0] d, input logic ordy, input logic fl);
    logic in_fire, out_fire;
    int n;
    @(negedge clk);
    in_valid = iv;
    in_data64 = d;
    out_ready = ordy;
    flush = fl;
    #1;
    check_outputs();
    n = q.size();
    in_fire = iv && (n < 2);
    out_fire = ordy && (n > 0);
    stall = (n > 0) && !ordy && !fl;
    stall_data = od64;
    if (out_fire) void'(q.pop_front());
    if (fl) q.delete();
    else if (in_fire) q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic iv, input logic [63:0] d, input logic ordy,
                              input logic fl, input logic eov, input logic eir,
                              input logic [1:0] eocc, input logic cd, input logic [63:0] eod);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.eov = eov; v.eir = eir; v.eocc = eocc; v.cd = cd; v.eod = eod;
    return v;
  endfunction

  initial begin
    // Expected outputs are those seen just after the edge that consumes each vector.
    tbl[0]  = mk(1, 64'h1,  1, 0, 1, 1, 2'd1, 1, 64'h1);
    tbl[1]  = mk(1, 64'h2,  1, 0, 1, 1, 2'd1, 1, 64'h2);
    tbl[2]  = mk(1, 64'h3,  1, 0, 1, 1, 2'd1, 1, 64'h3);
    tbl[3]  = mk(0, 64'h0,  1, 0, 0, 1, 2'd0, 0, 64'h0);
    tbl[4]  = mk(1, 64'hA,  0, 0, 1, 1, 2'd1, 1, 64'hA);
    tbl[5]  = mk(1, 64'hB,  0, 0, 1, 0, 2'd2, 1, 64'hA);
    tbl[6]  = mk(1, 64'hEE, 1, 0, 1, 1, 2'd1, 1, 64'hB);
    tbl[7]  = mk(0, 64'h0,  1, 0, 0, 1, 2'd0, 0, 64'h0);
    tbl[8]  = mk(1, 64'h5,  0, 0, 1, 1, 2'd1, 1, 64'h5);
    tbl[9]  = mk(1, 64'h6,  1, 0, 1, 1, 2'd1, 1, 64'h6);
    tbl[10] = mk(1, 64'h7,  0, 0, 1, 0, 2'd2, 1, 64'h6);
    tbl[11] = mk(1, 64'hC,  0, 1, 0, 1, 2'd0, 0, 64'h0);
    tbl[12] = mk(0, 64'h0,  1, 0, 0, 1, 2'd0, 0, 64'h0);
    tbl[13] = mk(1, 64'h8,  0, 0, 1, 1, 2'd1, 1, 64'h8);
    tbl[14] = mk(1, 64'h9,  1, 1, 0, 1, 2'd0, 0, 64'h0);
    tbl[15] = mk(1, 64'hD,  1, 0, 1, 1, 2'd1, 1, 64'hD);
    tbl[16] = mk(1, 64'hF,  0, 1, 0, 1, 2'd0, 0, 64'h0);

    // Power-on reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov64", {63'd0, ov64}, 64'd0);
    chk("rst_ir64", {63'd0, ir64}, 64'd1);
    chk("rst_occ64", {62'd0, occ64}, 64'd0);
    chk("rst_od64", od64, RV64);
    chk("rst_od8", {56'd0, od8}, {56'd0, RV8});
    @(negedge clk);
    reset = 1'b0;

    // Directed table.
    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
      chk($sformatf("tbl%0d_ov", i), {63'd0, ov64}, {63'd0, tbl[i].eov});
      chk($sformatf("tbl%0d_ir", i), {63'd0, ir64}, {63'd0, tbl[i].eir});
      chk($sformatf("tbl%0d_occ", i), {62'd0, occ64}, {62'd0, tbl[i].eocc});
      if (tbl[i].cd) chk($sformatf("tbl%0d_od", i), od64, tbl[i].eod);
    end

    // Fill to FULL, then assert reset asynchronously mid-cycle.
    cycle(1, 64'h11, 0, 0);
    cycle(1, 64'h22, 0, 0);
    chk("pre_rst_occ", {62'd0, occ64}, 64'd2);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_ov64", {63'd0, ov64}, 64'd0);
    chk("async_ir64", {63'd0, ir64}, 64'd1);
    chk("async_occ64", {62'd0, occ64}, 64'd0);
    chk("async_od64", od64, RV64);
    chk("async_ov8", {63'd0, ov8}, 64'd0);
    chk("async_od8", {56'd0, od8}, {56'd0, RV8});
    q.delete();
    stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;

    // First post-reset edge behaves as EMPTY.
    cycle(1, 64'h33, 0, 0);
    chk("post_rst_od", od64, 64'h33);

    // Random handshake traffic.
    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom % 4) != 0, {$urandom, $urandom}, ($urandom % 3) != 0,
            ($urandom % 64) == 0);
    end
    cycle(0, 64'h0, 1, 0);
    cycle(0, 64'h0, 1, 0);
    cycle(0, 64'h0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
